// File: rtl/jtcontra_pcm.sv
// jtcontra_pcm: multi-channel 8-bit PCM player. Z80 programs start/volume/key,
// samples are fetched from PCM ROM per cen tick and mixed to 16b signed.
// Ports: clk, rst_n (async low), cen (sample tick), cs/wr_n/addr/din (CPU),
// dout (busy flags), rom_addr/rom_cs/rom_data/rom_ok (ROM), snd/sample (mix).
// Option: define JTCONTRA_PCM_LOOP_EN to honour the control loop bit.
module jtcontra_pcm #(
  parameter int CH = 2,
  parameter int AW = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic                  cs,
  input  logic                  wr_n,
  input  logic [2+$clog2(CH):0] addr,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [AW-1:0]         rom_addr,
  output logic                  rom_cs,
  input  logic [7:0]            rom_data,
  input  logic                  rom_ok,
  output logic signed [15:0]    snd,
  output logic                  sample
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_ADDR, S_WAIT, S_DONE
  } st_t;

  st_t                 st_q, st_d;
  logic [CW-1:0]       cur_q, cur_d;
  logic [AW-1:0]       raddr_q, raddr_d;
  logic [AW-1:0]       start_q [CH];
  logic [AW-1:0]       start_d [CH];
  logic [AW-1:0]       ptr_q [CH];
  logic [AW-1:0]       ptr_d [CH];
  logic [3:0]          vol_q [CH];
  logic [3:0]          vol_d [CH];
  logic signed [7:0]   smp_q [CH];
  logic signed [7:0]   smp_d [CH];
  logic [CH-1:0]       loop_q, loop_d;
  logic [CH-1:0]       busy_q, busy_d;
  logic [CH-1:0]       pend_q, pend_d;
  logic                we_q;
  logic signed [15:0]  snd_q, snd_d;
  logic                smpl_q, smpl_d;

  logic [CW+2:0]       addr_x;
  logic [CW-1:0]       wch;
  logic [2:0]          wreg;
  logic                wr_stb;
  logic [CH-1:0]       ws;
  logic                cap;
  logic [23:0]         s24;
  logic                go;
  logic [CW-1:0]       nxt;

  logic signed [12:0]  prod [CH];
  logic signed [19:0]  acc, shf;
  logic signed [15:0]  mix;

  function automatic logic [CW-1:0] first(
    input logic [CH-1:0] v
  );
    first = '0;
    for (int i = CH-1; i >= 0; i--)
      if (v[i]) first = CW'(i);
  endfunction

  // Write acts once per strobe: edge of cs && !wr_n
  assign addr_x = (CW+3)'(addr);
  assign wch    = addr_x[CW+2:3];
  assign wreg   = addr_x[2:0];
  assign wr_stb = cs && !wr_n && !we_q;

  always_comb begin
    ws = '0;
    for (int i = 0; i < CH; i++)
      ws[i] = wr_stb && (wch == CW'(i));
  end

  assign cap = (st_q == S_WAIT) && rom_ok;

  always_comb begin
    acc = '0;
    for (int i = 0; i < CH; i++) begin
      prod[i] = smp_q[i] * $signed({1'b0, vol_q[i]});
      acc = acc + 20'(prod[i]);
    end
    shf = acc <<< 4;
    if (shf > 20'sd32767)
      mix = 16'sh7fff;
    else if (shf < -20'sd32768)
      mix = 16'sh8000;
    else
      mix = shf[15:0];
  end

  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    loop_d = loop_q;
    s24    = '0;
    for (int i = 0; i < CH; i++) begin
      start_d[i] = start_q[i];
      ptr_d[i]   = ptr_q[i];
      vol_d[i]   = vol_q[i];
      smp_d[i]   = smp_q[i];
      // A control write to the channel being captured wins
      if (cap && cur_q == CW'(i) && busy_q[i] &&
          !(ws[i] && wreg == 3'd3)) begin
        if (rom_data != 8'h80) begin
          smp_d[i] = rom_data;
          ptr_d[i] = ptr_q[i] + 1'b1;
        end else begin
          smp_d[i] = '0;
`ifdef JTCONTRA_PCM_LOOP_EN
          if (loop_q[i])
            ptr_d[i] = start_q[i];
          else
            busy_d[i] = 1'b0;
`else
          busy_d[i] = 1'b0;
`endif
        end
      end
      if (cap && cur_q == CW'(i))
        pend_d[i] = 1'b0;
      // New tick requests survive a capture in the same cycle
      if (cen)
        pend_d[i] = pend_d[i] | busy_q[i];
      s24 = 24'(start_q[i]);
      if (ws[i]) begin
        unique case (1'b1)
          (wreg == 3'd0): begin
            s24[7:0]   = din;
            start_d[i] = AW'(s24);
          end
          (wreg == 3'd1): begin
            s24[15:8]  = din;
            start_d[i] = AW'(s24);
          end
          (wreg == 3'd2): begin
            s24[23:16] = din;
            start_d[i] = AW'(s24);
          end
          (wreg == 3'd3): begin
            vol_d[i]  = din[7:4];
            loop_d[i] = din[1];
            smp_d[i]  = '0;
            if (din[0]) begin
              ptr_d[i]  = start_q[i];
              busy_d[i] = 1'b1;
            end else begin
              busy_d[i] = 1'b0;
              pend_d[i] = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    cur_d   = cur_q;
    raddr_d = raddr_q;
    snd_d   = snd_q;
    smpl_d  = 1'b0;
    go      = 1'b0;
    nxt     = '0;
    unique case (st_q)
      S_IDLE: begin
        if (|pend_q) begin
          go  = 1'b1;
          nxt = first(pend_q);
        end else if (cen && !(|busy_q)) begin
          st_d = S_DONE;
        end
      end
      S_ADDR: st_d = S_WAIT;
      S_WAIT: begin
        if (rom_ok) begin
          if (|pend_d) begin
            go  = 1'b1;
            nxt = first(pend_d);
          end else begin
            st_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        st_d   = S_IDLE;
        snd_d  = mix;
        smpl_d = 1'b1;
      end
    endcase
    // Address is latched so it holds while rom_cs is high
    if (go) begin
      st_d  = S_ADDR;
      cur_d = nxt;
      for (int i = 0; i < CH; i++)
        if (nxt == CW'(i)) raddr_d = ptr_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      cur_q   <= '0;
      raddr_q <= '0;
      loop_q  <= '0;
      busy_q  <= '0;
      pend_q  <= '0;
      we_q    <= 1'b0;
      snd_q   <= '0;
      smpl_q  <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        start_q[i] <= '0;
        ptr_q[i]   <= '0;
        vol_q[i]   <= '0;
        smp_q[i]   <= '0;
      end
    end else begin
      st_q    <= st_d;
      cur_q   <= cur_d;
      raddr_q <= raddr_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      we_q    <= cs && !wr_n;
      snd_q   <= snd_d;
      smpl_q  <= smpl_d;
      for (int i = 0; i < CH; i++) begin
        start_q[i] <= start_d[i];
        ptr_q[i]   <= ptr_d[i];
        vol_q[i]   <= vol_d[i];
        smp_q[i]   <= smp_d[i];
      end
    end
  end

  assign dout     = 8'(busy_q);
  assign rom_addr = raddr_q;
  assign rom_cs   = (st_q == S_ADDR) || (st_q == S_WAIT);
  assign snd      = snd_q;
  assign sample   = smpl_q;

endmodule

// File: tb/tb_jtcontra_pcm.sv
// tb_jtcontra_pcm: scoreboard bench for jtcontra_pcm (CH=2, AW=17).
// ROM responder with programmable latency; monitor checks snd per sample.
module tb_jtcontra_pcm;
  localparam int CH = 2;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic cs = 1'b0;
  logic wr_n = 1'b1;
  logic [3:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic [AW-1:0] rom_addr;
  logic rom_cs;
  logic [7:0] rom_data;
  logic rom_ok;
  logic signed [15:0] snd;
  logic sample;

  logic [7:0] rom [0:(1<<AW)-1];
  int n_cmp = 0;
  int n_bad = 0;
  int lat = 0;
  int cnt = 0;
  logic ok = 1'b0;
  logic [AW-1:0] lat_addr = '0;
  logic [AW-1:0] fetchq [$];
  int expq [$];
  int mon_e;
  int kw_m;

  jtcontra_pcm #(.CH(CH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs(cs),
    .wr_n(wr_n), .addr(addr), .din(din), .dout(dout),
    .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok),
    .snd(snd), .sample(sample)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];
  assign rom_ok   = ok;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  // ROM model: ok pulses lat+1 cycles after a fetch starts
  always @(posedge clk) begin
    if (!rom_cs) begin
      ok <= 1'b0;
      cnt <= 0;
    end else if (ok) begin
      ok <= 1'b0;
      cnt <= 0;
    end else begin
      if (cnt == 0) begin
        lat_addr <= rom_addr;
        fetchq.push_back(rom_addr);
      end
      if (cnt >= lat) ok <= 1'b1;
      else cnt <= cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rom_ok)
      chk("addr_stable", int'(rom_addr), int'(lat_addr));
    if (rst_n && sample) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_sample: got %0d want none", snd);
      end else begin
        mon_e = expq.pop_front();
        chk("snd", int'(snd), mon_e);
      end
    end
  end

  task automatic wr(input int ch, input int r, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr_n = 1'b0; addr = 4'(ch*8 + r); din = d;
    @(negedge clk);
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic set_start(input int ch, input int s);
    wr(ch, 0, 8'(s));
    wr(ch, 1, 8'(s >> 8));
    wr(ch, 2, 8'(s >> 16));
  endtask

  // One cen tick; elat>0 also checks cen-to-sample latency
  task automatic tick(input int e, input int elat);
    int n;
    expq.push_back(e);
    @(negedge clk); cen = 1'b1;
    @(posedge clk); n = 1;
    @(negedge clk); cen = 1'b0;
    while (!sample && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL sample_timeout: got none want pulse");
    end else if (elat > 0) begin
      chk("latency", n, elat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) rom[i] = 8'h00;
    rom[17'h100] = 8'h10; rom[17'h101] = 8'h20; rom[17'h102] = 8'h80;
    rom[17'h200] = 8'h7f; rom[17'h201] = 8'h80;
    rom[17'h300] = 8'h7f; rom[17'h301] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      rom[17'h400 + i] = 8'h11;
      rom[17'h500 + i] = 8'h22;
    end
    rom[17'h1ffff] = 8'h01; rom[0] = 8'h01; rom[1] = 8'h01;
    rom[17'h600] = 8'h05; rom[17'h601] = 8'h80;

    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_rom_cs", int'(rom_cs), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_snd", int'(snd), 0);
    chk("rst_sample", int'(sample), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single channel 10,20,80
    lat = 0;
    set_start(0, 'h100);
    wr(0, 3, 8'hF1);
    chk("keyon_dout", int'(dout), 1);
    tick(3840, 5);
    tick(7680, 0);
    tick(0, 0);
    chk("end_dout", int'(dout), 0);
    tick(0, 2);

    // two channels, slow ROM, saturation
    lat = 5;
    set_start(0, 'h200);
    set_start(1, 'h300);
    wr(0, 3, 8'hF1);
    wr(1, 3, 8'hF1);
    chk("two_dout", int'(dout), 3);
    fetchq.delete();
    tick(32767, 0);
    chk("order_n", fetchq.size(), 2);
    chk("order0", int'(fetchq[0]), 'h200);
    chk("order1", int'(fetchq[1]), 'h300);
    tick(0, 0);
    chk("two_end_dout", int'(dout), 0);

    // key-off ch1 coincident with its rom_ok
    lat = 0;
    set_start(0, 'h400);
    set_start(1, 'h500);
    wr(0, 3, 8'hF1);
    wr(1, 3, 8'hF1);
    tick(12240, 0);
    fork
      tick(4080, 0);
      begin
        kw_m = 0;
        do begin
          @(negedge clk);
          kw_m++;
        end while (!(rom_ok && rom_addr == 17'h501) && kw_m < 200);
        if (kw_m >= 200) begin
          n_cmp++; n_bad++;
          $display("FAIL koff_wait: got no fetch want 0x501");
        end else begin
          cs = 1'b1; wr_n = 1'b0; addr = 4'(8 + 3); din = 8'h00;
          @(negedge clk);
          cs = 1'b0; wr_n = 1'b1;
        end
      end
    join
    chk("koff_dout", int'(dout), 1);
    tick(4080, 0);
    wr(0, 3, 8'h00);

    // pointer wrap
    set_start(0, 'h1ffff);
    wr(0, 3, 8'hF1);
    tick(240, 5);
    fetchq.delete();
    tick(240, 0);
    chk("wrap_n", fetchq.size(), 1);
    chk("wrap_addr", int'(fetchq[0]), 0);
    chk("wrap_dout", int'(dout), 1);
    wr(0, 3, 8'h00);

    // loop bit
    set_start(0, 'h600);
    wr(0, 3, 8'hF3);
    tick(1200, 0);
    tick(0, 0);
`ifdef JTCONTRA_PCM_LOOP_EN
    tick(1200, 0);
    chk("loop_dout", int'(dout), 1);
`else
    tick(0, 0);
    chk("loop_dout", int'(dout), 0);
`endif
    wr(0, 3, 8'h00);

    // reset during WAIT
    set_start(0, 'h100);
    wr(0, 3, 8'hF1);
    tick(3840, 5);
    lat = 20;
    @(negedge clk); cen = 1'b1;
    @(negedge clk); cen = 1'b0;
    kw_m = 0;
    while (!rom_cs && kw_m < 20) begin
      @(negedge clk);
      kw_m++;
    end
    repeat (3) @(negedge clk);
    chk("pre_rst_rom_cs", int'(rom_cs), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rom_cs", int'(rom_cs), 0);
    chk("mid_rst_rom_addr", int'(rom_addr), 0);
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_snd", int'(snd), 0);
    chk("mid_rst_sample", int'(sample), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("queue_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
